// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial stimulus feeder: accepts one word over valid/ready and
// shifts it out LSB-first on out_bit, holding each bit for hold+1 cycles.
module serial_bit_feeder #(
  parameter int WIDTH  = 8,
  parameter int LEN_W  = 4,
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [WIDTH-1:0]  load_data,
  input  logic [LEN_W-1:0]  load_len,
  input  logic [HOLD_W-1:0] load_hold,
  input  logic              abort,
  output logic              out_bit,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] WIDTH_LEN = LEN_W'(WIDTH);

  state_t              state_reg, state_next;
  logic [WIDTH-1:0]    shift_reg, shift_next;
  logic [LEN_W-1:0]    len_reg, len_next;
  logic [HOLD_W-1:0]   hold_reg, hold_next;
  logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic [LEN_W-1:0]    bit_cnt_reg, bit_cnt_next;

  logic load_ready_reg, load_ready_next;
  logic out_bit_reg, out_bit_next;
  logic out_valid_reg, out_valid_next;
  logic busy_reg, busy_next;
  logic done_reg, done_next;

  logic [LEN_W-1:0] eff_len;
  logic             handshake;
  logic             last_hold;
  logic             last_bit;
  logic [WIDTH-1:0] shifted;

  // Words longer than the shifter are clamped so stray high bits never leak out.
  assign eff_len   = (load_len > WIDTH_LEN) ? WIDTH_LEN : load_len;
  assign handshake = load_valid && load_ready_reg;
  assign last_hold = (hold_cnt_reg == hold_reg);
  assign last_bit  = (bit_cnt_reg == (len_reg - LEN_W'(1)));

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == WIDTH - 1) begin : g_top
        assign shifted[gi] = 1'b0;
      end else begin : g_mid
        assign shifted[gi] = shift_reg[gi+1];
      end
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    len_next      = len_reg;
    hold_next     = hold_reg;
    hold_cnt_next = hold_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (handshake) begin
          shift_next    = load_data;
          len_next      = eff_len;
          hold_next     = load_hold;
          hold_cnt_next = '0;
          bit_cnt_next  = '0;
          state_next    = (eff_len == '0) ? DONE : SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        // Abort takes priority over completing the final bit.
        if (abort) begin
          state_next    = IDLE;
          shift_next    = '0;
          hold_cnt_next = '0;
          bit_cnt_next  = '0;
        end else if (last_hold) begin
          hold_cnt_next = '0;
          if (last_bit) begin
            state_next   = DONE;
            bit_cnt_next = '0;
            shift_next   = '0;
          end else begin
            bit_cnt_next = bit_cnt_reg + LEN_W'(1);
            shift_next   = shifted;
          end
        end else begin
          hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs are derived from next state so they land in registers.
    load_ready_next = (state_next != SHIFT);
    busy_next       = (state_next == SHIFT);
    out_valid_next  = (state_next == SHIFT);
    out_bit_next    = (state_next == SHIFT) && shift_next[0];
    done_next       = (state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      shift_reg      <= '0;
      len_reg        <= '0;
      hold_reg       <= '0;
      hold_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      load_ready_reg <= 1'b1;
      out_bit_reg    <= 1'b0;
      out_valid_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shift_reg      <= shift_next;
      len_reg        <= len_next;
      hold_reg       <= hold_next;
      hold_cnt_reg   <= hold_cnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      load_ready_reg <= load_ready_next;
      out_bit_reg    <= out_bit_next;
      out_valid_reg  <= out_valid_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
    end
  end

  assign load_ready = load_ready_reg;
  assign out_bit    = out_bit_reg;
  assign out_valid  = out_valid_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;

endmodule
